// File: rtl/syndrome_read_arbiter.sv
// syndrome_read_arbiter
// Shares the single read port of the syndrome coefficient store between four
// streaming consumers. Requester 0 is the error-locator path. Requesters 1-3
// are the unmodified-syndrome consumers. Each requester walks addresses
// 1..number_of_coefs in order. Words from different requesters are
// interleaved under round-robin arbitration.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-low
//   new_codeword     one-cycle pulse: restart every stream, drop in-flight read
//   syndromes_avail  level: store holds a complete syndrome set
//   req[3:0]         per-requester level request
//   mem_rd_en        store read strobe (combinational)
//   mem_rd_addr      store read address, 0 when idle (combinational)
//   mem_rd_data      store read data, valid one cycle after mem_rd_en
//   coef_data        delivered coefficient
//   coef_addr        address of coef_data
//   coef_valid[3:0]  one-hot owner of coef_data/coef_addr
//   done[3:0]        pulse alongside a requester's last coefficient
//   busy             a read is being issued or is in flight
module syndrome_read_arbiter #(
  parameter int unsigned width           = 6,
  parameter int unsigned number_of_coefs = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             new_codeword,
  input  logic             syndromes_avail,
  input  logic [3:0]       req,
  output logic             mem_rd_en,
  output logic [width-1:0] mem_rd_addr,
  input  logic [7:0]       mem_rd_data,
  output logic [7:0]       coef_data,
  output logic [width-1:0] coef_addr,
  output logic [3:0]       coef_valid,
  output logic [3:0]       done,
  output logic             busy
);

  localparam int unsigned num_req = 4;
  localparam logic [width-1:0] first_addr = width'(1);
  localparam logic [width-1:0] last_addr  = width'(number_of_coefs);

  logic [width-1:0]   cnt [num_req];
  logic [num_req-1:0] fin;
  logic [1:0]         ptr;

  logic               s1_valid;
  logic [1:0]         s1_id;
  logic [width-1:0]   s1_addr;
  logic               s1_last;

  logic [num_req-1:0] elig;
  logic               gnt_any;
  logic [1:0]         gnt_id;
  logic [1:0]         scan_idx;

  // No grants while reset is held: such a read would be discarded anyway.
  assign elig = req & ~fin & {num_req{syndromes_avail & ~new_codeword & reset}};

  // Round-robin pick: first eligible index starting at ptr, wrapping mod 4.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = ptr;
    scan_idx = ptr;
    for (int unsigned k = 0; k < num_req; k++) begin
      scan_idx = ptr + 2'(k);
      if (!gnt_any && elig[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  assign mem_rd_en   = gnt_any;
  assign mem_rd_addr = gnt_any ? cnt[gnt_id] : '0;
  assign busy        = gnt_any | s1_valid;

  // Stream counters, arbitration pointer, read pipeline and delivery registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < num_req; i++) begin
        cnt[i] <= first_addr;
      end
      fin        <= '0;
      ptr        <= 2'd0;
      s1_valid   <= 1'b0;
      s1_id      <= 2'd0;
      s1_addr    <= '0;
      s1_last    <= 1'b0;
      coef_data  <= 8'd0;
      coef_addr  <= '0;
      coef_valid <= 4'd0;
      done       <= 4'd0;
    end else begin
      for (int unsigned i = 0; i < num_req; i++) begin
        if (new_codeword) begin
          cnt[i] <= first_addr;
          fin[i] <= 1'b0;
        end else if (gnt_any && (gnt_id == 2'(i))) begin
          // Last word of the set: mark finished and park the counter.
          if (cnt[i] == last_addr) begin
            fin[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + width'(1);
          end
        end else if (fin[i] && !req[i]) begin
          // Request dropped after a full burst: rearm for the next one.
          fin[i] <= 1'b0;
          cnt[i] <= first_addr;
        end
      end

      if (gnt_any) begin
        ptr <= gnt_id + 2'd1;
      end

      s1_valid <= gnt_any;
      s1_id    <= gnt_id;
      s1_addr  <= cnt[gnt_id];
      s1_last  <= (cnt[gnt_id] == last_addr);

      // A new codeword arriving while the read is in flight cancels delivery.
      if (s1_valid && !new_codeword) begin
        coef_data  <= mem_rd_data;
        coef_addr  <= s1_addr;
        coef_valid <= 4'b0001 << s1_id;
        done       <= s1_last ? (4'b0001 << s1_id) : 4'd0;
      end else begin
        coef_data  <= 8'd0;
        coef_addr  <= '0;
        coef_valid <= 4'd0;
        done       <= 4'd0;
      end
    end
  end

endmodule
